uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small TX FIFO. The frame format (divisor, data bits,
// parity, stop bits) is sampled at each frame start.
// Optional feature macro UART_TX_BREAK_EN adds a brk input that holds the line low between
// frames and stalls FIFO pops.
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [3:0]                  data_bits,
  input  logic [1:0]                  parity_type,
  input  logic                        stop_bits,
`ifdef UART_TX_BREAK_EN
  input  logic                        brk,
`endif
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        tx,
  output logic                        tx_active,
  output logic                        tx_done
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);
  localparam logic [3:0] BitsMax = 4'(DATA_W);

  logic brk_eff;
`ifdef UART_TX_BREAK_EN
  assign brk_eff = brk;
`else
  assign brk_eff = 1'b0;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, empty_q, overflow_q;
  logic              push, pop;

  // A write is judged against the registered full flag, so a same-cycle pop does not rescue it.
  assign push = wr_en & ~full_q;

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Occupancy after this cycle's push and pop.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  // Pointers, registered status flags and the sticky overflow flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LevelFull);
      empty_q <= (level_d == '0);
      if (wr_en && full_q) overflow_q <= 1'b1;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;

  // ----------------------------------------------------------- Serializer
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d, baud_cnt_q, baud_cnt_d;
  logic [3:0]        nbits_q, nbits_d, bit_cnt_q, bit_cnt_d;
  logic [1:0]        par_q, par_d;
  logic              stop2_q, stop2_d, acc_q, acc_d, tx_q, tx_d, active_q, active_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              bit_end, last_stop, load, par_bit;
  logic [3:0]        nbits_clamped;

  assign nbits_clamped = (data_bits < 4'd5)    ? 4'd5    :
                         (data_bits > BitsMax) ? BitsMax : data_bits;
  assign bit_end   = (baud_cnt_q == div_q);
  // In two-stop mode bit_cnt_q marks the second stop bit.
  assign last_stop = !stop2_q || (bit_cnt_q == 4'd1);
  // acc_q is the XOR of the data bits already sent.
  assign par_bit   = (par_q == 2'b01) ? ~acc_q : (par_q == 2'b10) ? acc_q : 1'b1;

  // Next-state, bit sequencing and frame start (FIFO pop plus format latch).
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    acc_d      = acc_q;
    tx_d       = tx_q;
    active_d   = active_q;
    shift_d    = shift_q;
    baud_cnt_d = (state_q == StIdle || bit_end) ? '0 : baud_cnt_q + DIV_W'(1);
    load       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d     = ~brk_eff;
        active_d = 1'b0;
        load     = ~empty_q & ~brk_eff;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          tx_d      = shift_q[0];
          acc_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 4'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == nbits_q) begin
            bit_cnt_d = '0;
            if (par_q == 2'b00) begin
              state_d = StStop;
              tx_d    = 1'b1;
            end else begin
              state_d = StParity;
              tx_d    = par_bit;
            end
          end else begin
            tx_d      = shift_q[0];
            acc_d     = acc_q ^ shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (!last_stop) begin
            bit_cnt_d = 4'd1;
          end else begin
            load = ~empty_q & ~brk_eff;
            if (!load) begin
              state_d  = StIdle;
              tx_d     = ~brk_eff;
              active_d = 1'b0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      pop        = 1'b1;
      state_d    = StStart;
      tx_d       = 1'b0;
      active_d   = 1'b1;
      shift_d    = mem_q[rd_ptr_q];
      div_d      = baud_div;
      nbits_d    = nbits_clamped;
      par_d      = parity_type;
      stop2_d    = stop_bits;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  // Serializer state; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      baud_cnt_q <= '0;
      nbits_q    <= 4'd5;
      bit_cnt_q  <= '0;
      par_q      <= '0;
      stop2_q    <= 1'b0;
      acc_q      <= 1'b0;
      tx_q       <= 1'b1;
      active_q   <= 1'b0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      nbits_q    <= nbits_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      acc_q      <= acc_d;
      tx_q       <= tx_d;
      active_q   <= active_d;
      shift_q    <= shift_d;
    end
  end

  assign tx        = tx_q;
  assign tx_active = active_q;
  // High during the final clock of the last stop bit.
  assign tx_done   = (state_q == StStop) && bit_end && last_stop;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes push expected words, a monitor rebuilds each frame
// from the format in force at frame start and checks the serial line clock by clock.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic [DIV_W-1:0]  baud_div = 16'd3;
  logic [3:0]        data_bits = 4'd8;
  logic [1:0]        parity_type = 2'd0;
  logic              stop_bits = 1'b0;
  logic              brk = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              full, empty, overflow, tx, tx_active, tx_done;
  logic [LW-1:0]     level;

  uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .arst_n(arst_n), .baud_div(baud_div), .data_bits(data_bits),
    .parity_type(parity_type), .stop_bits(stop_bits),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .tx(tx), .tx_active(tx_active), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              b2b;  // frame must follow the previous one with no idle clock
  } exp_t;

  exp_t exp_q[$];
  bit   fb[$];
  int   checks = 0;
  int   failures = 0;

  // Format inputs as seen by the DUT at the most recent clock edge.
  logic [DIV_W-1:0] s_div = '0;
  logic [3:0]       s_bits = '0;
  logic [1:0]       s_par = '0;
  logic             s_stop = 1'b0, s_brk = 1'b0;
  always @(posedge clk) begin
    s_div  <= baud_div;
    s_bits <= data_bits;
    s_par  <= parity_type;
    s_stop <= stop_bits;
    s_brk  <= brk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Reference frame: start, clamped data LSB first, optional parity, stop bit(s).
  function automatic void build_frame(input logic [DATA_W-1:0] d, input int bits, input int par,
                                      input bit two);
    int nb, ones;
    nb = (bits < 5) ? 5 : ((bits > int'(DATA_W)) ? int'(DATA_W) : bits);
    ones = 0;
    fb.delete();
    fb.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      fb.push_back(d[i]);
      if (d[i] === 1'b1) ones++;
    end
    case (par)
      1: fb.push_back((ones % 2) == 0);
      2: fb.push_back((ones % 2) == 1);
      3: fb.push_back(1'b1);
      default: ;
    endcase
    fb.push_back(1'b1);
    if (two) fb.push_back(1'b1);
  endfunction

  // Monitor: idle line checks and per-bit frame checks against the scoreboard.
  initial begin : monitor
    int gap;
    gap = 0;
    forever begin
      @(negedge clk);
      if (!tx_active) begin
        gap++;
        chk("idle_line", 32'({tx, tx_done}), 32'({(!arst_n || !s_brk), 1'b0}));
      end else if (exp_q.size() == 0) begin
        chk("frame_expected", 32'(exp_q.size()), 32'd1);
        for (int k = 0; k < 2000 && tx_active; k++) @(negedge clk);
        gap = 0;
      end else begin
        exp_t e;
        int   div;
        bit   aborted, done_ok;
        e = exp_q.pop_front();
        div = int'(s_div);
        build_frame(e.data, int'(s_bits), int'(s_par), s_stop);
        if (e.b2b) chk("b2b_gap", 32'(gap), 32'd0);
        gap = 0;
        aborted = 1'b0;
        done_ok = 1'b1;
        for (int i = 0; i < fb.size() && !aborted; i++) begin
          bit   bit_ok;
          logic got;
          bit_ok = 1'b1;
          got = tx;
          for (int c = 0; c <= div && !aborted; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (!arst_n) begin
              aborted = 1'b1;
            end else begin
              if (tx !== fb[i] || tx_active !== 1'b1) begin
                bit_ok = 1'b0;
                got = tx;
              end
              if (tx_done !== ((i == fb.size() - 1) && (c == div))) done_ok = 1'b0;
            end
          end
          if (!aborted) begin
            checks++;
            if (!bit_ok) begin
              failures++;
              $display("FAIL frame_bit: data=%0h bit %0d got tx=%0b want %0b", e.data, i, got,
                       fb[i]);
            end
          end
        end
        if (!aborted) chk("tx_done_pulse", 32'(done_ok), 32'd1);
      end
    end
  end

  task automatic cfg(input int d, input int b, input int p, input int s);
    baud_div    = DIV_W'(d);
    data_bits   = 4'(b);
    parity_type = 2'(p);
    stop_bits   = 1'(s);
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    @(negedge clk);
    if (exp_q.size() < FIFO_DEPTH) begin
      wr_en = 1'b1;
      wr_data = d;
      exp_q.push_back({d, 1'b0});
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((exp_q.size() != 0 || tx_active) && k < 5000);
    chk("drain_done", 32'(exp_q.size() == 0 && !tx_active), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (tx_done !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("tx_done_seen", 32'(tx_done), 32'd1);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin : stim
    int bad;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_active", 32'(tx_active), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    cfg(3, 8, 0, 0); wr(8'hD5); drain();    // 8N1
    cfg(1, 8, 2, 1); wr(8'hD5); drain();    // 8E2
    cfg(1, 8, 1, 0); wr(8'hD5); drain();    // 8O1
    cfg(0, 7, 3, 0); wr(8'hD5); drain();    // 7 bits, mark parity, one clock per bit
    cfg(2, 2, 0, 0); wr(8'h3A); drain();    // clamps up to 5 bits
    cfg(0, 15, 2, 1); wr(8'hA7); drain();   // clamps down to DATA_W bits

    // Format change mid-frame applies only to the next frame.
    cfg(2, 8, 0, 0); wr(8'h5C); wr(8'hC3);
    repeat (5) @(negedge clk);
    cfg(1, 6, 1, 1);
    drain();
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_level", 32'(level), 32'd0);
    chk("no_overflow_yet", 32'(overflow), 32'd0);

    // Ten consecutive writes: one popped at once, eight stored, the tenth dropped.
    cfg(3, 8, 0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = DATA_W'(8'h40 + k);
      if (k < 9) exp_q.push_back({DATA_W'(8'h40 + k), k >= 1});
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_empty", 32'(empty), 32'd0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Random traffic and formats.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (cyc % 250 == 0)
        cfg(int'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
            int'($urandom_range(3, 0)), int'($urandom_range(1, 0)));
      if ($urandom_range(3, 0) == 0 && exp_q.size() < FIFO_DEPTH) begin
        wr_en = 1'b1;
        wr_data = DATA_W'($urandom);
        exp_q.push_back({wr_data, 1'b0});
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    drain();

`ifdef UART_TX_BREAK_EN
    // Break raised mid-frame: frame completes, line held low, queued word waits.
    cfg(1, 8, 0, 0);
    wr(8'h96); wr(8'h69);
    repeat (4) @(negedge clk);
    brk = 1'b1;
    wait_done(100);
    repeat (15) @(negedge clk);
    chk("brk_tx_low", 32'(tx), 32'd0);
    chk("brk_inactive", 32'(tx_active), 32'd0);
    chk("brk_level", 32'(level), 32'd1);
    brk = 1'b0;
    drain();
`endif

    // Reset during the data bits of the second of three queued frames.
    cfg(3, 8, 0, 0);
    wr(8'h11); wr(8'h22); wr(8'h33);
    wait_done(200);
    repeat (10) @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_active", 32'(tx_active), 32'd0);
    chk("arst_done", 32'(tx_done), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done !== 1'b0 || tx_active !== 1'b0) bad++;
    end
    chk("post_reset_quiet", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
